// File: rtl/rv32i_trap_ctrl_if.sv
// Core-side bundle of the RV32I machine-mode trap controller: exception/interrupt
// inputs, CSR access port, trap/return redirect handshakes and exported CSR values.
interface rv32i_trap_ctrl_if #(
    parameter int NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] irq_i;
    logic [31:0]        irq_pc;
    logic               exc_valid;
    logic [3:0]         exc_code;
    logic [31:0]        exc_pc;
    logic [31:0]        exc_tval;
    logic               mret;
    logic               csr_we;
    logic [1:0]         csr_addr;
    logic [31:0]        csr_wdata;
    logic [31:0]        csr_rdata;
    logic               trap_valid;
    logic [31:0]        trap_pc;
    logic               trap_ready;
    logic               ret_valid;
    logic [31:0]        ret_pc;
    logic               ret_ready;
    logic [31:0]        mepc;
    logic [31:0]        mcause;
    logic [31:0]        mtval;
    logic               in_handler;

    modport slave (
        input  irq_i, irq_pc, exc_valid, exc_code, exc_pc, exc_tval, mret,
               csr_we, csr_addr, csr_wdata, trap_ready, ret_ready,
        output csr_rdata, trap_valid, trap_pc, ret_valid, ret_pc,
               mepc, mcause, mtval, in_handler
    );

    modport master (
        output irq_i, irq_pc, exc_valid, exc_code, exc_pc, exc_tval, mret,
               csr_we, csr_addr, csr_wdata, trap_ready, ret_ready,
        input  csr_rdata, trap_valid, trap_pc, ret_valid, ret_pc,
               mepc, mcause, mtval, in_handler
    );
endinterface

// File: rtl/rv32i_trap_ctrl.sv
// Machine-mode trap controller: exception/interrupt arbitration, trap CSRs and the
// trap-entry / mret-return handshake. Define TRAP_VECTORED_EN for vectored interrupts.
module rv32i_trap_ctrl #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input logic              clk,
    input logic              rst,
    rv32i_trap_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP,
        S_HANDLER,
        S_RET
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] mip_q, mip_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [31:0]        mtval_q, mtval_d;
    logic [31:0]        trap_pc_q, trap_pc_d;
    logic               mstatus_mie_q, mstatus_mie_d;
    logic               mstatus_mpie_q, mstatus_mpie_d;

    logic               accepting;
    logic [NUM_IRQ-1:0] irq_active;
    logic               irq_pending;
    logic [3:0]         irq_idx;
    logic [4:0]         irq_cause;
    logic               take_exc;
    logic               take_irq;
    logic               take_trap;
    logic               take_mret;
    logic               hw_event;
    logic [31:0]        mtvec_base;

    // Arbitration: exception over interrupt, lowest interrupt index first, any trap over mret.
    always_comb begin
        accepting   = (state_q == S_IDLE) || (state_q == S_HANDLER);
        irq_active  = mip_q & mie_q;
        irq_pending = accepting && mstatus_mie_q && (|irq_active);
        irq_idx     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_active[i]) irq_idx = 4'(i);
        end
        irq_cause  = 5'd16 + {1'b0, irq_idx};
        take_exc   = accepting && bus.exc_valid;
        take_irq   = irq_pending && !take_exc;
        take_trap  = take_exc || take_irq;
        take_mret  = (state_q == S_HANDLER) && bus.mret && !take_trap;
        hw_event   = take_trap || take_mret;
        mtvec_base = {mtvec_q[31:2], 2'b00};
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        mip_d          = bus.irq_i;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        trap_pc_d      = trap_pc_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;

        // Software writes first; a trap or mret on the same edge overrides mstatus/mepc.
        if (bus.csr_we) begin
            case (bus.csr_addr)
                2'd0: begin
                    if (!hw_event) begin
                        mstatus_mie_d  = bus.csr_wdata[3];
                        mstatus_mpie_d = bus.csr_wdata[7];
                    end
                end
                2'd1:    mie_d   = bus.csr_wdata[NUM_IRQ-1:0];
                2'd2:    mtvec_d = bus.csr_wdata;
                default: begin
                    if (!hw_event) mepc_d = {bus.csr_wdata[31:2], 2'b00};
                end
            endcase
        end

        case (state_q)
            S_IDLE, S_HANDLER: begin
                if (take_trap) begin
                    state_d        = S_TRAP;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                    if (take_exc) begin
                        mepc_d   = bus.exc_pc;
                        mcause_d = {28'b0, bus.exc_code};
                        mtval_d  = bus.exc_tval;
                    end else begin
                        mepc_d   = bus.irq_pc;
                        mcause_d = {1'b1, 26'b0, irq_cause};
                        mtval_d  = '0;
                    end
`ifdef TRAP_VECTORED_EN
                    trap_pc_d = (take_irq && (mtvec_q[1:0] == 2'b01))
                              ? mtvec_base + {25'b0, irq_cause, 2'b00}
                              : mtvec_base;
`else
                    trap_pc_d = mtvec_base;
`endif
                end else if (take_mret) begin
                    state_d        = S_RET;
                    mstatus_mie_d  = mstatus_mpie_q;
                    mstatus_mpie_d = 1'b1;
                end
            end
            S_TRAP:  if (bus.trap_ready) state_d = S_HANDLER;
            S_RET:   if (bus.ret_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mip_q          <= '0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            trap_pc_q      <= '0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mip_q          <= mip_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            trap_pc_q      <= trap_pc_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
        end
    end

    // Handshake outputs decode straight from the state flop so reset drops them at once.
    assign bus.trap_valid = (state_q == S_TRAP);
    assign bus.ret_valid  = (state_q == S_RET);
    assign bus.in_handler = (state_q == S_HANDLER);
    assign bus.trap_pc    = trap_pc_q;
    assign bus.ret_pc     = mepc_q;
    assign bus.mepc       = mepc_q;
    assign bus.mcause     = mcause_q;
    assign bus.mtval      = mtval_q;

    always_comb begin
        case (bus.csr_addr)
            2'd0:    bus.csr_rdata = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            2'd1:    bus.csr_rdata = 32'(mie_q);
            2'd2:    bus.csr_rdata = mtvec_q;
            default: bus.csr_rdata = mepc_q;
        endcase
    end
endmodule

// File: tb/tb_rv32i_trap_ctrl.sv
// Self-checking bench for rv32i_trap_ctrl: a trap-semantics model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rv32i_trap_ctrl;
    localparam int NUM_IRQ = 4;
`ifdef TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif
    localparam int M_IDLE = 0, M_TRAP = 1, M_HAND = 2, M_RET = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    rv32i_trap_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();

    rv32i_trap_ctrl #(
        .NUM_IRQ    (NUM_IRQ),
        .MTVEC_RESET(32'h0000_0100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model of the trap rules.
    int                 m_st;
    logic [NUM_IRQ-1:0] m_mip, m_mie;
    logic [31:0]        m_mtvec, m_mepc, m_mcause, m_mtval, m_trap_pc;
    bit                 m_gie, m_pie;

    function automatic void model_reset();
        m_st = M_IDLE; m_mip = '0; m_mie = '0; m_mtvec = 32'h100;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_trap_pc = 0;
        m_gie = 0; m_pie = 0;
    endfunction

    function automatic void model_step();
        bit          can_trap = (m_st == M_IDLE) || (m_st == M_HAND);
        int          winner = -1;
        bit          exc, irq, ret, event_now;
        logic [31:0] old_tvec = m_mtvec;
        bit          old_gie = m_gie, old_pie = m_pie;
        int          cause;
        if (can_trap && m_gie)
            for (int i = NUM_IRQ - 1; i >= 0; i--)
                if (m_mip[i] && m_mie[i]) winner = i;
        exc = can_trap && bus.exc_valid;
        irq = !exc && (winner >= 0);
        ret = !exc && !irq && (m_st == M_HAND) && bus.mret;
        event_now = exc || irq || ret;
        if (bus.csr_we) begin
            if (bus.csr_addr == 1) m_mie = bus.csr_wdata[NUM_IRQ-1:0];
            if (bus.csr_addr == 2) m_mtvec = bus.csr_wdata;
            if (bus.csr_addr == 0 && !event_now) begin
                m_gie = bus.csr_wdata[3];
                m_pie = bus.csr_wdata[7];
            end
            if (bus.csr_addr == 3 && !event_now) m_mepc = bus.csr_wdata & ~32'h3;
        end
        if (exc || irq) begin
            cause     = 16 + winner;
            m_mepc    = exc ? bus.exc_pc : bus.irq_pc;
            m_mcause  = exc ? 32'(bus.exc_code) : (32'h8000_0000 | 32'(cause));
            m_mtval   = exc ? bus.exc_tval : 32'h0;
            m_pie     = old_gie;
            m_gie     = 0;
            m_trap_pc = old_tvec & ~32'h3;
            if (VEC && irq && old_tvec[1:0] == 2'b01) m_trap_pc = m_trap_pc + 4 * cause;
            m_st = M_TRAP;
        end else if (ret) begin
            m_gie = old_pie;
            m_pie = 1;
            m_st  = M_RET;
        end else if (m_st == M_TRAP && bus.trap_ready) begin
            m_st = M_HAND;
        end else if (m_st == M_RET && bus.ret_ready) begin
            m_st = M_IDLE;
        end
        m_mip = bus.irq_i;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return (m_pie ? 32'h80 : 32'h0) | (m_gie ? 32'h8 : 32'h0);
            2'd1:    return 32'(m_mie);
            2'd2:    return m_mtvec;
            default: return m_mepc;
        endcase
    endfunction

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        check("cmp_trap_valid", 32'(bus.trap_valid), 32'(m_st == M_TRAP));
        check("cmp_ret_valid", 32'(bus.ret_valid), 32'(m_st == M_RET));
        check("cmp_in_handler", 32'(bus.in_handler), 32'(m_st == M_HAND));
        check("cmp_mepc", bus.mepc, m_mepc);
        check("cmp_mcause", bus.mcause, m_mcause);
        check("cmp_mtval", bus.mtval, m_mtval);
        check("cmp_csr_rdata", bus.csr_rdata, model_rdata(bus.csr_addr));
        if (m_st == M_TRAP) check("cmp_trap_pc", bus.trap_pc, m_trap_pc);
        if (m_st == M_RET) check("cmp_ret_pc", bus.ret_pc, m_mepc);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        bus.csr_we = 1; bus.csr_addr = a; bus.csr_wdata = d;
        cyc();
        bus.csr_we = 0; bus.csr_addr = 2'd0; bus.csr_wdata = 0;
    endtask

    task automatic handshake_home();
        bus.trap_ready = 1; cyc(); bus.trap_ready = 0;
        bus.mret = 1;       cyc(); bus.mret = 0;
        bus.ret_ready = 1;  cyc(); bus.ret_ready = 0;
    endtask

    initial begin
        bus.irq_i = '0; bus.irq_pc = 0; bus.exc_valid = 0; bus.exc_code = 0;
        bus.exc_pc = 0; bus.exc_tval = 0; bus.mret = 0; bus.csr_we = 0;
        bus.csr_addr = 0; bus.csr_wdata = 0; bus.trap_ready = 0; bus.ret_ready = 0;
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_trap_valid", 32'(bus.trap_valid), 0);
        check("rst_mepc", bus.mepc, 0);
        bus.csr_addr = 2'd2; #1;
        check("rst_mtvec", bus.csr_rdata, 32'h100);
        bus.csr_addr = 2'd0;
        cyc();

        // Synchronous exception from IDLE.
        bus.exc_valid = 1; bus.exc_code = 4'd2; bus.exc_pc = 32'h40; bus.exc_tval = 32'hDEAD;
        cyc();
        bus.exc_valid = 0;
        check("exc_trap_valid", 32'(bus.trap_valid), 1);
        check("exc_trap_pc", bus.trap_pc, 32'h100);
        check("exc_mepc", bus.mepc, 32'h40);
        check("exc_mcause", bus.mcause, 32'h2);
        check("exc_mtval", bus.mtval, 32'hDEAD);
        check("exc_mie", 32'(bus.csr_rdata[3]), 0);
        bus.trap_ready = 1; cyc(); bus.trap_ready = 0;
        check("exc_in_handler", 32'(bus.in_handler), 1);
        bus.mret = 1; cyc(); bus.mret = 0;
        check("exc_ret_pc", bus.ret_pc, 32'h40);
        check("exc_mstatus_after_mret", bus.csr_rdata, 32'h80);
        bus.ret_ready = 1; cyc(); bus.ret_ready = 0;
        check("exc_back_idle", 32'(bus.ret_valid | bus.in_handler), 0);

        // Interrupt: lowest enabled pending index wins, two-cycle latency, hold until ready.
        csr_write(2'd1, 32'h6);
        csr_write(2'd0, 32'h8);
        check("irq_mstatus", bus.csr_rdata, 32'h08);
        bus.irq_pc = 32'h500; bus.irq_i = 4'b0110;
        cyc();
        check("irq_lat1", 32'(bus.trap_valid), 0);
        cyc();
        bus.irq_i = '0;
        check("irq_trap_valid", 32'(bus.trap_valid), 1);
        check("irq_mcause", bus.mcause, 32'h8000_0011);
        check("irq_mepc", bus.mepc, 32'h500);
        check("irq_mstatus_entry", bus.csr_rdata, 32'h80);
        repeat (3) begin
            cyc();
            check("irq_hold", 32'(bus.trap_valid), 1);
        end
        bus.trap_ready = 1; cyc(); bus.trap_ready = 0;
        check("irq_accept", 32'(bus.trap_valid), 0);

        // mret with MPIE=1 restores MIE.
        bus.mret = 1; cyc(); bus.mret = 0;
        check("ret_valid", 32'(bus.ret_valid), 1);
        check("ret_pc", bus.ret_pc, 32'h500);
        check("ret_mstatus", bus.csr_rdata, 32'h88);
        cyc();
        check("ret_hold", 32'(bus.ret_valid), 1);
        bus.ret_ready = 1; cyc(); bus.ret_ready = 0;
        check("ret_idle", 32'(bus.ret_valid | bus.in_handler), 0);

        // mret in IDLE is ignored.
        bus.mret = 1; cyc(); bus.mret = 0;
        check("idle_mret_ignored", 32'(bus.ret_valid), 0);
        check("idle_mret_mstatus", bus.csr_rdata, 32'h88);

        // Exception and pending interrupt together: exception wins.
        bus.irq_i = 4'b0010;
        cyc();
        bus.exc_valid = 1; bus.exc_code = 4'd5; bus.exc_pc = 32'h60; bus.exc_tval = 32'h11;
        cyc();
        bus.exc_valid = 0; bus.irq_i = '0;
        check("both_mcause", bus.mcause, 32'h5);
        check("both_mepc", bus.mepc, 32'h60);
        handshake_home();

        // Vectored dispatch (or plain base without the macro); later mtvec writes don't move trap_pc.
        csr_write(2'd2, 32'h201);
        bus.irq_pc = 32'h700; bus.irq_i = 4'b0100;
        cyc(); cyc();
        check("vec_trap_valid", 32'(bus.trap_valid), 1);
        check("vec_mcause", bus.mcause, 32'h8000_0012);
        check("vec_trap_pc", bus.trap_pc, VEC ? 32'h248 : 32'h200);
        csr_write(2'd2, 32'h300);
        bus.irq_i = '0;
        check("vec_trap_pc_stable", bus.trap_pc, VEC ? 32'h248 : 32'h200);

        // Asynchronous reset in the middle of a trap handshake.
        check("pre_rst_trap_valid", 32'(bus.trap_valid), 1);
        #2 rst = 1;
        #1;
        check("async_rst_trap_valid", 32'(bus.trap_valid), 0);
        check("async_rst_mepc", bus.mepc, 0);
        repeat (2) cyc();
        rst = 0;
        repeat (3) begin
            cyc();
            check("post_rst_no_trap", 32'(bus.trap_valid), 0);
        end
        bus.csr_addr = 2'd2; #1;
        check("post_rst_mtvec", bus.csr_rdata, 32'h100);
        bus.csr_addr = 2'd0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/rv32i_trap_ctrl.md
# rv32i_trap_ctrl

Parametrised machine-mode trap controller for the RV32I core. It arbitrates synchronous exceptions against NUM_IRQ level-sensitive interrupt lines and maintains mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause and mtval. It runs a trap-entry / mret-return handshake with the core's fetch stage. It sits between the execute/CSR stage and the PC-select logic.

## Interface
- NUM_IRQ, 4: number of interrupt lines; legal range 1..16.
- MTVEC_RESET, 32'h0000_0100: reset value of mtvec.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- irq_i  in  NUM_IRQ  level interrupt requests.
- irq_pc  in  32  PC of the next instruction to execute; becomes mepc for interrupts.
- exc_valid  in  1  synchronous exception this cycle.
- exc_code  in  4  exception cause code.
- exc_pc  in  32  PC of the faulting instruction.
- exc_tval  in  32  trap value.
- mret  in  1  mret retired this cycle.
- csr_we  in  1  CSR write strobe.
- csr_addr  in  2  CSR select: 0=mstatus, 1=mie, 2=mtvec, 3=mepc.
- csr_wdata  in  32  CSR write data.
- csr_rdata  out  32  combinational read of the CSR selected by csr_addr.
- trap_valid  out  1  redirect the core to trap_pc.
- trap_pc  out  32  handler address.
- trap_ready  in  1  core accepted the trap redirect.
- ret_valid  out  1  redirect the core to ret_pc.
- ret_pc  out  32  return address; equals mepc.
- ret_ready  in  1  core accepted the return redirect.
- mepc, mcause, mtval  out  32 each  CSR values.
- in_handler  out  1  high in HANDLER state.

## Operation
- States: IDLE, TRAP, HANDLER, RET.
- mip is irq_i registered once per cycle, masked to NUM_IRQ bits.
- Interrupt pending: state is IDLE or HANDLER, MIE=1, and |(mip & mie) is true.
- Priority:
  - exc_valid beats any interrupt.
  - Among interrupts, the lowest index wins.
  - An exception or interrupt beats mret in the same cycle; that mret is discarded.
- Trap entry from IDLE or HANDLER, all updates on one edge:
  - mepc <= exc_pc (exception) or irq_pc (interrupt).
  - mcause <= {1'b0, 27'b0, exc_code} (exception) or {1'b1, 26'b0, 5'd16+idx} (interrupt).
  - mtval <= exc_tval (exception) or 0 (interrupt).
  - MPIE <= MIE; MIE <= 0; state <= TRAP.
- TRAP: trap_valid=1 and is held until trap_ready; the accepting edge moves the state to HANDLER.
- HANDLER: mret moves the state to RET, sets MIE <= MPIE and MPIE <= 1.
- RET: ret_valid=1 and is held until ret_ready; the accepting edge moves the state to IDLE.
- exc_valid, mret and interrupts are ignored in TRAP and RET, because the core is stalled.
- mret in IDLE is ignored (no state change, no CSR change).
- CSR writes:
  - mstatus: only bits 3 (MIE) and 7 (MPIE) are writable; all other bits read 0.
  - mie: only bits [NUM_IRQ-1:0] are writable.
  - mtvec: bits [31:2] hold the base and bits [1:0] the mode.
  - mepc: bits [1:0] are forced to 0.
- On the edge of trap entry or mret, hardware updates beat a concurrent csr_we to mstatus or mepc. csr_we to mie and mtvec still takes effect.
- csr_rdata reflects register state before the current edge.
- trap_pc is computed from mtvec at TRAP entry and registered, so later mtvec writes do not change it.

## Timing
- Reset values:
  - mepc, mcause, mtval, mie, mip, MIE, MPIE = 0.
  - mtvec = MTVEC_RESET.
  - state = IDLE; trap_valid, ret_valid and in_handler = 0.
- exc_valid or a pending interrupt sampled at edge N gives trap_valid=1 from N+1, with the CSRs already updated.
- irq_i to trap_valid is at least 2 cycles: 1 for the mip register, 1 for entry.
- If trap_ready is already high in the first TRAP cycle, trap_valid is high for exactly 1 cycle.
- mret at edge N gives ret_valid=1 from N+1.
- Reset asserted mid-handshake drops trap_valid and ret_valid immediately (asynchronous).

## Configuration
- TRAP_VECTORED_EN defined: if mtvec[1:0]==2'b01, interrupts go to trap_pc = base + 4*cause[4:0]; exceptions always go to base.
- TRAP_VECTORED_EN undefined: the mode bits are stored and readable but ignored; trap_pc = {mtvec[31:2], 2'b00} for all traps.

## Test plan
- Reset, then exc_valid with exc_code=2, exc_pc=0x40, exc_tval=0xDEAD -> next cycle:
  - trap_valid=1, trap_pc=0x100, mepc=0x40, mcause=0x2, mtval=0xDEAD, MIE=0.
- MIE=1, mie=4'b0110, irq_i=4'b0110:
  - two cycles later trap_valid=1 with mcause=0x8000_0011 (idx 1), mepc=irq_pc.
  - Held through 3 cycles of trap_ready=0; drops on the cycle after trap_ready=1.
- exc_valid and a pending interrupt in the same cycle -> exception taken with mcause[31]=0.
- mret in HANDLER with MPIE=1:
  - ret_valid=1, ret_pc=mepc; MIE=1 afterwards; state returns to IDLE after ret_ready.
- TRAP_VECTORED_EN set, mtvec=0x201, irq 2 taken -> trap_pc=0x248. Without the macro -> trap_pc=0x200.
- rst asserted while trap_valid=1 -> trap_valid=0 and mepc=0 without waiting for a clock edge; no trap after release.
